tff_mod_counter: RTL and testbench

Parametrised synchronous up/down modulo counter, the successor to the fixed 4-bit enable-only T-flip-flop counter.
- Generalised in width and modulus.
- Adds direction control, parallel load, one-shot/wrap mode, and a combinational terminal-count output so instances cascade into wider or decade chains.
- Used as a general event/time-base counter in lab designs and testbenches.

---
 rtl/tff_mod_counter_pkg.sv | 18 +
 rtl/tff_mod_counter_sync.sv | 27 ++
 rtl/tff_mod_counter.sv | 95 +++++++++
 tb/tb_tff_mod_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tff_mod_counter_pkg.sv
// Shared constants for the modulo counter family: direction/mode encodings,
// run/halt state encoding and the legal-parameter predicate.
package tff_mod_counter_pkg;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Two-state run control; HALT is what DONE reports.
  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  function automatic bit params_legal(int width, int modulus);
    return (width >= 2) && (width <= 16) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/tff_mod_counter_sync.sv
// Single-bit T flip-flop with synchronous active-high clear and synchronous load.
module tff_sync (
  input  logic CK,
  input  logic CLR,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ld)     q_d = d;
    else if (t) q_d = ~q_q;
  end

  always_ff @(posedge CK) begin
    if (CLR) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Parametrised up/down modulo counter built from T flip-flops, with load,
// wrap/one-shot mode, combinational terminal count and registered WRAP/DONE.
module tff_mod_counter
  import tff_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             E,
  input  logic             UD,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             ONESHOT,
  output logic [WIDTH-1:0] q,
  output logic             TC,
  output logic             WRAP,
  output logic             DONE
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("tff_mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] t_bits;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   step;
  logic             up;
  logic             at_term;
  logic             cnt_en;
  logic             state_q, state_d;
  logic             wrap_q, wrap_d;

  // Terminal detection uses the extra bit: up hits MODULUS exactly, down borrows out of 0.
  always_comb begin
    q_ext   = {1'b0, q_w};
    up      = (UD == DIR_UP);
    step    = up ? (q_ext + ONE_W) : (q_ext - ONE_W);
    at_term = up ? (step == MOD_W) : step[WIDTH];
    cnt_en  = E && (state_q == ST_RUN);
    ld_val  = ({1'b0, D} < MOD_W) ? D : TOP_V;

    cnt_d   = q_w;
    state_d = state_q;
    wrap_d  = 1'b0;
    if (LD) begin
      state_d = ST_RUN;
    end else if (cnt_en) begin
      if (!at_term) begin
        cnt_d = step[WIDTH-1:0];
      end else if (ONESHOT == MODE_ONESHOT) begin
        state_d = ST_HALT;
      end else begin
        cnt_d  = (UD == DIR_DOWN) ? TOP_V : '0;
        wrap_d = 1'b1;
      end
    end
    t_bits = q_w ^ cnt_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_sync u_bit (
      .CK  (CK),
      .CLR (CLR),
      .t   (t_bits[i]),
      .ld  (LD),
      .d   (ld_val[i]),
      .q   (q_w[i])
    );
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      state_q <= ST_RUN;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = q_w;
  assign TC   = cnt_en & at_term;
  assign WRAP = wrap_q;
  assign DONE = (state_q == ST_HALT);

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter: arithmetic reference model checked every cycle,
// plus directed sequences with literal expected values.
module tb_tff_mod_counter;

  typedef struct {
    int q;
    bit wrap;
    bit done;
  } mstate_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MODULUS=10
  logic       a_clr, a_e, a_ud, a_ld, a_os;
  logic [3:0] a_d, a_q;
  logic       a_tc, a_wrap, a_done;
  // Instance B: WIDTH=4, MODULUS=16
  logic       b_clr, b_e, b_ud, b_ld, b_os;
  logic [3:0] b_d, b_q;
  logic       b_tc, b_wrap, b_done;
  // Cascade: two MODULUS=10 stages
  logic       c_clr, c_e, c_ud, c_ld, c_os;
  logic [3:0] c_d, lo_q, hi_q;
  logic       lo_tc, lo_wrap, lo_done, hi_tc, hi_wrap, hi_done;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_a (
    .CK(clk), .CLR(a_clr), .E(a_e), .UD(a_ud), .LD(a_ld), .D(a_d), .ONESHOT(a_os),
    .q(a_q), .TC(a_tc), .WRAP(a_wrap), .DONE(a_done));

  tff_mod_counter #(.WIDTH(4), .MODULUS(16)) u_b (
    .CK(clk), .CLR(b_clr), .E(b_e), .UD(b_ud), .LD(b_ld), .D(b_d), .ONESHOT(b_os),
    .q(b_q), .TC(b_tc), .WRAP(b_wrap), .DONE(b_done));

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .CK(clk), .CLR(c_clr), .E(c_e), .UD(c_ud), .LD(c_ld), .D(c_d), .ONESHOT(c_os),
    .q(lo_q), .TC(lo_tc), .WRAP(lo_wrap), .DONE(lo_done));

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .CK(clk), .CLR(c_clr), .E(lo_tc), .UD(c_ud), .LD(c_ld), .D(c_d), .ONESHOT(c_os),
    .q(hi_q), .TC(hi_tc), .WRAP(hi_wrap), .DONE(hi_done));

  int  n_chk = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;
  mstate_t ma = '{0, 1'b0, 1'b0};
  mstate_t mb = '{0, 1'b0, 1'b0};
  int  mc = 0;

  function automatic mstate_t mnext(mstate_t s, bit clr, bit ld, bit e, bit ud, bit os,
                                    int d, int m);
    mstate_t n = s;
    if (clr) begin
      n = '{0, 1'b0, 1'b0};
    end else if (ld) begin
      n.q = (d < m) ? d : m - 1;
      n.wrap = 1'b0;
      n.done = 1'b0;
    end else if (e && !s.done) begin
      if (ud ? (s.q == m - 1) : (s.q == 0)) begin
        if (os) begin
          n.done = 1'b1;
          n.wrap = 1'b0;
        end else begin
          n.q = ud ? 0 : m - 1;
          n.wrap = 1'b1;
        end
      end else begin
        n.q = ud ? (s.q + 1) % m : (s.q + m - 1) % m;
        n.wrap = 1'b0;
      end
    end else begin
      n.wrap = 1'b0;
    end
    return n;
  endfunction

  function automatic bit mtc(mstate_t s, bit e, bit ud, int m);
    return e && !s.done && (ud ? (s.q == m - 1) : (s.q == 0));
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    ma = mnext(ma, a_clr, a_ld, a_e, a_ud, a_os, int'(a_d), 10);
    mb = mnext(mb, b_clr, b_ld, b_e, b_ud, b_os, int'(b_d), 16);
    if (c_clr)    mc = 0;
    else if (c_e) mc = (mc + 1) % 100;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_a_q",    int'(a_q),    ma.q);
      chk("model_a_tc",   int'(a_tc),   int'(mtc(ma, a_e, a_ud, 10)));
      chk("model_a_wrap", int'(a_wrap), int'(ma.wrap));
      chk("model_a_done", int'(a_done), int'(ma.done));
      chk("model_b_q",    int'(b_q),    mb.q);
      chk("model_b_tc",   int'(b_tc),   int'(mtc(mb, b_e, b_ud, 16)));
      chk("model_b_wrap", int'(b_wrap), int'(mb.wrap));
      chk("model_b_done", int'(b_done), int'(mb.done));
      chk("model_cascade", int'(hi_q) * 10 + int'(lo_q), mc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(bit clr, bit ld, bit e, bit ud, bit os, int d);
    a_clr = clr; a_ld = ld; a_e = e; a_ud = ud; a_os = os; a_d = 4'(d);
  endtask

  int exp1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp2[9]  = '{6, 5, 4, 3, 2, 1, 0, 9, 8};

  initial begin
    set_a(1, 0, 0, 1, 0, 0);
    b_clr = 1'b1; b_e = 1'b0; b_ud = 1'b1; b_ld = 1'b0; b_os = 1'b0; b_d = 4'd0;
    c_clr = 1'b1; c_e = 1'b0; c_ud = 1'b1; c_ld = 1'b0; c_os = 1'b0; c_d = 4'd0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset_q", int'(a_q), 0);
    chk("reset_wrap", int'(a_wrap), 0);
    chk("reset_done", int'(a_done), 0);
    b_clr = 1'b0;
    c_clr = 1'b0;

    // Up count in wrap mode
    set_a(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_q", int'(a_q), exp1[i]);
      chk("up_wrap", int'(a_wrap), (i == 9) ? 1 : 0);
    end

    // Load 7 then count down through 0 -> 9
    set_a(0, 1, 0, 0, 0, 7);
    tick();
    chk("load7_q", int'(a_q), 7);
    set_a(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("down_q", int'(a_q), exp2[i]);
      chk("down_wrap", int'(a_wrap), (i == 7) ? 1 : 0);
    end

    // One-shot up from 8
    set_a(0, 1, 0, 1, 1, 8);
    tick();
    chk("os_load_q", int'(a_q), 8);
    set_a(0, 0, 1, 1, 1, 0);
    tick();
    chk("os_q1", int'(a_q), 9);
    chk("os_done1", int'(a_done), 0);
    tick();
    chk("os_q2", int'(a_q), 9);
    chk("os_done2", int'(a_done), 1);
    chk("os_tc_after_done", int'(a_tc), 0);
    tick();
    chk("os_q3", int'(a_q), 9);
    chk("os_wrap", int'(a_wrap), 0);
    set_a(0, 1, 0, 1, 1, 3);
    tick();
    chk("os_reload_q", int'(a_q), 3);
    chk("os_reload_done", int'(a_done), 0);

    // Saturating load
    set_a(0, 1, 0, 1, 0, 13);
    tick();
    chk("load13_q", int'(a_q), 9);
    b_ld = 1'b1; b_d = 4'd15;
    tick();
    chk("b_load15_q", int'(b_q), 15);
    b_ld = 1'b0; b_e = 1'b1;
    tick();
    chk("b_wrap_q", int'(b_q), 0);
    chk("b_wrap_pulse", int'(b_wrap), 1);
    b_e = 1'b0;
    tick();
    chk("b_wrap_clear", int'(b_wrap), 0);

    // Simultaneous controls
    set_a(1, 1, 1, 1, 0, 5);
    tick();
    chk("clr_over_ld_q", int'(a_q), 0);
    set_a(0, 1, 1, 1, 0, 4);
    tick();
    chk("ld_over_e_q", int'(a_q), 4);
    set_a(0, 1, 0, 1, 1, 9);
    tick();
    set_a(0, 0, 1, 1, 1, 0);
    tick();
    chk("os_done_again", int'(a_done), 1);
    set_a(1, 0, 1, 1, 1, 0);
    tick();
    chk("clr_done", int'(a_done), 0);
    chk("clr_q", int'(a_q), 0);
    set_a(0, 0, 1, 0, 1, 0);
    tick();
    chk("os_down_done", int'(a_done), 1);
    chk("os_down_q", int'(a_q), 0);
    set_a(0, 0, 1, 1, 0, 0);
    tick();
    chk("halt_ignores_e_q", int'(a_q), 0);
    chk("halt_sticky_done", int'(a_done), 1);

    // Two-stage decade cascade
    c_e = 1'b1;
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 45)  chk("cascade_45",  int'(hi_q) * 10 + int'(lo_q), 45);
      if (i == 100) chk("cascade_100", int'(hi_q) * 10 + int'(lo_q), 0);
      if (i == 101) chk("cascade_101", int'(hi_q) * 10 + int'(lo_q), 1);
    end
    c_e = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
